guarded_secret_rom: RTL

Parametrised read-only secret store for the badge challenge fabric. A synchronous ROM is placed behind an access guard. The guard has a key-entry unlock state machine, an optional lockout after failed attempts, and a single-cycle read pipeline. The permission decision is registered alongside the ROM data, so data and verdict always refer to the same address. The block sits between the challenge UART/SPI command decoder and the secret contents.

---
 rtl/guarded_rom_pkg.sv | 31 +++
 rtl/guarded_rom_array.sv | 18 +
 rtl/guarded_secret_rom.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/guarded_rom_pkg.sv
// Shared constants, FSM state type, ROM image and key for the guarded secret ROM.
// Optional lockout feature is enabled with GUARDED_ROM_LOCKOUT_EN.
package guarded_rom_pkg;

  localparam int ROM_DEPTH      = 32;
  localparam int KEY_BYTES      = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 1024;

  localparam logic [7:0] DENY_DEFAULT = 8'h3F;

  typedef enum logic [1:0] {
    LOCKED,
    COLLECT,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam logic [7:0] ROM_INIT [0:ROM_DEPTH-1] = '{
    8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
    8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF,
    8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7,
    8'hB8, 8'hB9, 8'hBA, 8'hBB, 8'hBC, 8'hBD, 8'hBE, 8'hBF
  };

  // "gb25"
  localparam logic [7:0] KEY [0:KEY_BYTES-1] = '{
    8'h67, 8'h62, 8'h32, 8'h35
  };

endpackage

// File: rtl/guarded_rom_array.sv
// Plain synchronous ROM loaded from the package image.
// Registered output, no reset.
module guarded_rom_array
  import guarded_rom_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    data <= DATA_W'(ROM_INIT[addr]);
  end

endmodule

// File: rtl/guarded_secret_rom.sv
// Secret ROM behind a key-entry guard with aligned permission pipeline.
// Define GUARDED_ROM_LOCKOUT_EN to build the failed-attempt lockout.
module guarded_secret_rom
  import guarded_rom_pkg::*;
#(
  parameter int                ADDR_W      = 5,
  parameter int                DATA_W      = 8,
  parameter int                PUBLIC_BASE = 31,
  parameter int                KEY_LEN     = KEY_BYTES,
  parameter logic [DATA_W-1:0] DENY_VALUE  = DATA_W'(DENY_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_denied,
  input  logic              key_valid,
  input  logic [7:0]        key_byte,
  input  logic              relock,
  output logic              unlocked,
  output logic              locked_out
);

  localparam int IW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(KEY_LEN - 1);
  localparam logic [ADDR_W:0] PUB = (ADDR_W + 1)'(PUBLIC_BASE);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            match;
  logic            byte_ok;
  logic            attempt_ok;
  logic            permit;
  logic            have_resp;
  logic [DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr;

  // Hold the last requested address so the ROM register keeps its word.
  assign rom_addr = rd_req ? rd_addr : addr_q;

  guarded_rom_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_q)
  );

  assign permit = (state == UNLOCKED) || ({1'b0, rd_addr} >= PUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_denied <= 1'b0;
      have_resp <= 1'b0;
      addr_q    <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_denied <= !permit;
        have_resp <= 1'b1;
        addr_q    <= rd_addr;
      end
    end
  end

  // A denied verdict masks the ROM word in the same cycle it appears.
  assign rd_data = !have_resp ? '0 : (rd_denied ? DENY_VALUE : rom_q);

  assign byte_ok    = (key_byte == KEY[idx]);
  assign attempt_ok = match && byte_ok;

`ifdef GUARDED_ROM_LOCKOUT_EN
  localparam int CW = $clog2(LOCKOUT_CYCLES);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] LAST_FAIL = FW'(MAX_FAILS - 1);

  logic [FW-1:0] fails;
  logic [CW-1:0] cnt;
`else
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOCKED;
      idx      <= '0;
      match    <= 1'b0;
      unlocked <= 1'b0;
`ifdef GUARDED_ROM_LOCKOUT_EN
      fails      <= '0;
      cnt        <= '0;
      locked_out <= 1'b0;
`endif
    end else begin
      case (state)
        LOCKED: begin
          if (key_valid) begin
            match <= byte_ok;
            idx   <= IW'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (key_valid) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (attempt_ok) begin
                state    <= UNLOCKED;
                unlocked <= 1'b1;
`ifdef GUARDED_ROM_LOCKOUT_EN
                fails    <= '0;
`endif
              end else begin
`ifdef GUARDED_ROM_LOCKOUT_EN
                fails <= fails + 1'b1;
                if (fails == LAST_FAIL) begin
                  state      <= LOCKOUT;
                  locked_out <= 1'b1;
                  cnt        <= '0;
                end else begin
                  state <= LOCKED;
                end
`else
                state <= LOCKED;
`endif
              end
            end else begin
              idx   <= idx + 1'b1;
              match <= attempt_ok;
            end
          end
        end
        UNLOCKED: begin
          if (relock) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end
        end
`ifdef GUARDED_ROM_LOCKOUT_EN
        LOCKOUT: begin
          if (cnt == LAST_CNT) begin
            state      <= LOCKED;
            locked_out <= 1'b0;
            fails      <= '0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: state <= LOCKED;
      endcase
    end
  end

endmodule
